// File: rtl/ps2_keyboard_slave_pkg.sv
// Shared bus definitions for the PS/2 keyboard slave: widths, register offsets,
// status bit positions and the frame validity check.
package ps2_keyboard_slave_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned SLAVE_WIDTH = 4;
    localparam int unsigned ADDR_W      = XLEN - SLAVE_WIDTH;
    localparam int unsigned CODE_W      = 8;
    localparam int unsigned FRAME_W     = 11;

    localparam logic [3:0] KBD_DATA = 4'h0;
    localparam logic [3:0] KBD_STAT = 4'h4;

    localparam int unsigned STAT_NONEMPTY = 0;
    localparam int unsigned STAT_OVF      = 1;

    // Frame is stored with the start bit at [0] and the stop bit at [10].
    function automatic logic frame_ok(input logic [FRAME_W-1:0] frame);
        return (frame[0] == 1'b0) && (frame[FRAME_W-1] == 1'b1) && (^frame[9:1]);
    endfunction

endpackage

// File: rtl/ps2_keyboard_slave_ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, samples one bit per falling
// ps2_clk edge, validates the 11-bit frame and pulses valid_o with the code.
module ps2_keyboard_slave_ps2_rx
    import ps2_keyboard_slave_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk_i,
    input  logic              ps2_data_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned BIT_W = 4;

    logic [2:0]         clk_sync_q, data_sync_q;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               valid_q, valid_d;
    logic               fall_c;

    // Index 0 is nearest the pad; a falling edge is the newer stage low after the older high.
    assign fall_c = ~clk_sync_q[1] & clk_sync_q[2];

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        if (fall_c) begin
            shift_d = {data_sync_q[1], shift_q[FRAME_W-1:1]};
            tmo_d   = '0;
            if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                bit_cnt_d = '0;
                if (frame_ok(shift_d)) begin
                    valid_d = 1'b1;
                    code_d  = shift_d[CODE_W:1];
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end else if (bit_cnt_q != '0) begin
            // Abandon a partial frame after TIMEOUT quiet cycles.
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                bit_cnt_d = '0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[1:0], ps2_data_i};
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
        end
    end

    assign code_o  = code_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ps2_keyboard_slave.sv
// PS/2 keyboard as a read-only uib slave: received scan codes are queued in a
// FIFO and polled by the CPU through the DATA and STATUS registers.
module ps2_keyboard_slave
    import ps2_keyboard_slave_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic [XLEN-1:0]   slave_dat_i,
    output logic [XLEN-1:0]   slave_dat_o,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic [2:0]        slave_mode,
    input  logic              slave_wen,
    input  logic              slave_req,
    output logic              slave_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   dat_q, dat_d;
    logic              ready_q;
    logic [CODE_W-1:0] rx_code;
    logic              rx_valid;
    logic              empty_c, full_c, rd_c, pop_c, push_c, ovf_evt_c, stat_rd_c;
    logic [XLEN-1:0]   stat_c, rdata_c;
    logic              unused_c;

    ps2_keyboard_slave_ps2_rx #(.TIMEOUT(TIMEOUT)) u_ps2_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .code_o     (rx_code),
        .valid_o    (rx_valid)
    );

    assign unused_c = ^{slave_dat_i, slave_mode, slave_addr[ADDR_W-1:4], slave_addr[1:0]};

    always_comb begin
        empty_c   = (count_q == '0);
        full_c    = (count_q == CNT_W'(FIFO_DEPTH));
        rd_c      = slave_req & ~slave_wen;
        pop_c     = rd_c && (slave_addr[3:2] == KBD_DATA[3:2]) && !empty_c;
        stat_rd_c = rd_c && (slave_addr[3:2] == KBD_STAT[3:2]);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push_c    = rx_valid && (!full_c || pop_c);
        ovf_evt_c = rx_valid && full_c && !pop_c;

        stat_c                = '0;
        stat_c[STAT_NONEMPTY] = !empty_c;
        stat_c[STAT_OVF]      = ovf_q;

        rdata_c = '0;
        if (rd_c) begin
            if (pop_c)          rdata_c = XLEN'(mem_q[rd_ptr_q]);
            else if (stat_rd_c) rdata_c = stat_c;
        end

        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);

        ovf_d = ovf_q;
        if (ovf_evt_c)      ovf_d = 1'b1;
        else if (stat_rd_c) ovf_d = 1'b0;

        dat_d = slave_req ? rdata_c : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            dat_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            dat_q    <= dat_d;
            ready_q  <= slave_req;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= rx_code;
    end

    assign slave_dat_o = dat_q;
    assign slave_ready = ready_q;

endmodule

// File: tb/tb_ps2_keyboard_slave.sv
// Bench for ps2_keyboard_slave: drives PS/2 frames and checks bus reads
// against a queue of expected scan codes and a modelled overflow flag.
module tb_ps2_keyboard_slave;
    import ps2_keyboard_slave_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 200;
    localparam int unsigned HP    = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ps2_clk = 1'b1;
    logic              ps2_data = 1'b1;
    logic [XLEN-1:0]   slave_dat_i = '0;
    logic [XLEN-1:0]   slave_dat_o;
    logic [ADDR_W-1:0] slave_addr = '0;
    logic [2:0]        slave_mode = 3'd2;
    logic              slave_wen = 1'b0;
    logic              slave_req = 1'b0;
    logic              slave_ready;

    logic [7:0] exp_q[$];
    logic       ovf_m = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    ps2_keyboard_slave #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .slave_dat_i (slave_dat_i),
        .slave_dat_o (slave_dat_o),
        .slave_addr  (slave_addr),
        .slave_mode  (slave_mode),
        .slave_wen   (slave_wen),
        .slave_req   (slave_req),
        .slave_ready (slave_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cycles(HP);
        ps2_clk = 1'b0;
        cycles(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par = 1'b0,
                              input logic bad_stop = 1'b0, input int nbits = 11);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        cycles(HP);
        if (!flip_par && !bad_stop && nbits == 11) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(code);
            else ovf_m = 1'b1;
        end
    endtask

    task automatic bus_access(input logic [3:0] off, input logic wen, input string tag,
                              input logic [31:0] exp);
        slave_addr = ADDR_W'(off);
        slave_wen  = wen;
        slave_req  = 1'b1;
        cycles(1);
        slave_req  = 1'b0;
        slave_wen  = 1'b0;
        check({tag, "_rdy"}, 32'(slave_ready), 32'd1);
        check(tag, slave_dat_o, exp);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'd0;
        bus_access(KBD_DATA, 1'b0, tag, e);
    endtask

    task automatic read_stat(input string tag);
        logic [31:0] e;
        e = '0;
        e[STAT_NONEMPTY] = (exp_q.size() != 0);
        e[STAT_OVF]      = ovf_m;
        ovf_m = 1'b0;
        bus_access(KBD_STAT, 1'b0, tag, e);
    endtask

    initial begin
        cycles(3);
        check("rst_ready", 32'(slave_ready), 32'd0);
        check("rst_dat", slave_dat_o, 32'd0);
        rst = 1'b1;
        cycles(5);

        read_stat("stat_reset");
        read_data("data_empty");
        cycles(1);
        check("ready_idle", 32'(slave_ready), 32'd0);

        send_frame(8'h1C);
        read_stat("stat_one");
        bus_access(KBD_DATA, 1'b1, "write_data", 32'd0);
        read_stat("stat_after_write");
        read_data("data_1c");
        read_stat("stat_drained");

        send_frame(8'hF0);
        send_frame(8'h1C);
        read_data("data_f0");
        read_data("data_1c_2nd");

        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h3A, 1'b0, 1'b1);
        read_stat("stat_bad_frames");
        read_data("data_bad_frames");

        send_frame(8'hAA, 1'b0, 1'b0, 5);
        cycles(TMO + 50);
        send_frame(8'h29);
        read_data("data_after_tmo");
        read_stat("stat_after_tmo");

        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'(8'h10 + 3 * i));
        read_stat("stat_overflow");
        read_stat("stat_ovf_cleared");
        for (int i = 0; i < DEPTH + 1; i++) read_data($sformatf("fifo_rd%0d", i));
        read_stat("stat_fifo_drained");

        bus_access(4'h8, 1'b0, "read_off8", 32'd0);
        bus_access(4'hC, 1'b0, "read_offc", 32'd0);

        send_frame(8'h33);
        send_frame(8'h44, 1'b0, 1'b0, 4);
        rst = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        cycles(3);
        rst = 1'b1;
        ps2_data = 1'b1;
        cycles(TMO + 10);
        read_stat("stat_after_reset");
        send_frame(8'h5A);
        read_data("data_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
